// File: rtl/enc_pkg.sv
// Shared definitions for the instruction encoder: mnemonic codes, opcodes, FSM states.
// ENC_PSEUDO_EN adds the EXPAND state used by the two-word LI32 pseudo-instruction.
package enc_pkg;

  typedef enum logic [3:0] {
    MN_RTYPE = 4'd0,
    MN_LW    = 4'd1,
    MN_SW    = 4'd2,
    MN_BEQ   = 4'd3,
    MN_ADDI  = 4'd4,
    MN_J     = 4'd5,
    MN_LUI   = 4'd6,
    MN_LI    = 4'd7,
    MN_BLT   = 4'd8,
    MN_LI32  = 4'd9
  } enc_mnem_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_BLT   = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1
`ifdef ENC_PSEUDO_EN
    ,
    ST_EXPAND = 2'd2
`endif
  } enc_state_t;

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/enc_field.sv
// Branch offset and jump target field generation, each with its range-error flag.
// The offset is relative to pc+4 and counted in words (arithmetic shift).
module enc_field (
  input  logic [31:0] pc,
  input  logic [31:0] target,
  output logic [15:0] br_off,
  output logic        br_err,
  output logic [25:0] j_field,
  output logic        j_err
);

  logic [31:0] pc_plus4;
  logic [31:0] diff;
  logic [31:0] off;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    diff     = target - pc_plus4;
    off      = 32'($signed(diff) >>> 2);
    br_off   = off[15:0];
    // Fits in signed 16 bits only when the upper 17 bits are a pure sign extension.
    br_err   = (off[31:15] != {17{off[15]}}) || (target[1:0] != 2'b00);
    j_field  = target[27:2];
    j_err    = (target[31:28] != pc_plus4[31:28]) || (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: one request in, one (or two, for LI32) 32-bit words out.
// Optional macro ENC_PSEUDO_EN enables the LI32 pseudo-instruction and the EXPAND state.
module instr_encoder
  import enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] count
);

  enc_state_t  state_q, state_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic [15:0] count_q, count_d;

  logic [15:0] br_off;
  logic        br_err;
  logic [25:0] j_field;
  logic        j_err;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        enc_err;
  logic        in_xfer;
  logic        out_xfer;

`ifdef ENC_PSEUDO_EN
  logic [31:0] pend_q, pend_d;
  logic        enc_expand;
`else
  logic        unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:16];
`endif

  // Offsets are taken against pc_q: the address the incoming word will occupy.
  enc_field u_field (
    .pc      (pc_q),
    .target  (in_target),
    .br_off  (br_off),
    .br_err  (br_err),
    .j_field (j_field),
    .j_err   (j_err)
  );

  assign out_valid = (state_q != ST_IDLE);
  assign out_xfer  = out_valid && out_ready;
`ifdef ENC_PSEUDO_EN
  assign in_ready  = (!out_valid || out_ready) && (state_q != ST_EXPAND);
`else
  assign in_ready  = !out_valid || out_ready;
`endif
  assign in_xfer   = in_valid && in_ready;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    enc_err   = 1'b0;
`ifdef ENC_PSEUDO_EN
    enc_expand = 1'b0;
`endif
    case (enc_mnem_t'(in_mnem))
      MN_RTYPE: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, in_funct};
      MN_LW:    enc_word = i_word(OP_LW,   in_rs, in_rt, in_imm[15:0]);
      MN_SW:    enc_word = i_word(OP_SW,   in_rs, in_rt, in_imm[15:0]);
      MN_ADDI:  enc_word = i_word(OP_ADDI, in_rs, in_rt, in_imm[15:0]);
      MN_LI:    enc_word = i_word(OP_LI,   in_rs, in_rt, in_imm[15:0]);
      MN_LUI:   enc_word = i_word(OP_LUI,  5'b00000, in_rt, in_imm[15:0]);
      MN_BEQ: begin
        enc_word = i_word(OP_BEQ, in_rs, in_rt, br_off);
        enc_err  = br_err;
      end
      MN_BLT: begin
        enc_word = i_word(OP_BLT, in_rs, in_rt, br_off);
        enc_err  = br_err;
      end
      MN_J: begin
        enc_word = {OP_J, j_field};
        enc_err  = j_err;
      end
`ifdef ENC_PSEUDO_EN
      MN_LI32: begin
        enc_word   = i_word(OP_LUI, 5'b00000, in_rt, in_imm[31:16]);
        enc_expand = 1'b1;
      end
`endif
      default:  enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    pc_d        = pc_q;
    err_d       = err_q;
    count_d     = count_q;
`ifdef ENC_PSEUDO_EN
    pend_d      = pend_q;
`endif

    if (out_xfer) begin
      state_d = ST_IDLE;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end

`ifdef ENC_PSEUDO_EN
    // First LI32 word left; the pending LI word takes its place at the next address.
    if (out_xfer && state_q == ST_EXPAND) begin
      out_instr_d = pend_q;
      out_addr_d  = pc_q;
      pc_d        = pc_q + 32'd4;
      state_d     = ST_HOLD;
    end
`endif

    if (in_xfer) begin
      if (!enc_legal || enc_err) err_d = 1'b1;
      if (enc_legal) begin
        out_instr_d = enc_word;
        out_addr_d  = pc_q;
        pc_d        = pc_q + 32'd4;
        state_d     = ST_HOLD;
`ifdef ENC_PSEUDO_EN
        if (enc_expand) begin
          state_d = ST_EXPAND;
          pend_d  = i_word(OP_LI, in_rt, in_rt, in_imm[15:0]);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_instr_q <= 32'h0;
      out_addr_q  <= BASE_ADDR;
      pc_q        <= BASE_ADDR;
      err_q       <= 1'b0;
      count_q     <= 16'h0;
`ifdef ENC_PSEUDO_EN
      pend_q      <= 32'h0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      state_q     <= state_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      pc_q        <= pc_d;
      err_q       <= err_d;
      count_q     <= count_d;
`ifdef ENC_PSEUDO_EN
      pend_q      <= pend_d;
`endif
    end
  end

  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; inputs change after posedge, outputs
// are sampled on the falling edge. LI32 expansion is exercised when ENC_PSEUDO_EN is set.
module tb_instr_encoder;
  import enc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [31:0] in_imm, in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr, out_addr;
  logic        err;
  logic [15:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mnem   (in_mnem),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_funct  (in_funct),
    .in_imm    (in_imm),
    .in_target (in_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .count     (count)
  );

  task automatic set_req(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] f, input logic [31:0] imm,
                         input logic [31:0] tgt);
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = f; in_imm = imm; in_target = tgt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Present one request and hold it until accepted (bounded), then drop in_valid.
  task automatic issue(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] f, input logic [31:0] imm,
                       input logic [31:0] tgt);
    int n = 0;
    @(negedge clk);
    set_req(m, rs, rt, rd, f, imm, tgt);
    in_valid = 1'b1;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
    total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL rst_out_addr got=%h exp=0", out_addr); end
    total++; if (count !== 16'h0) begin bad++; $display("FAIL rst_count got=%h exp=0", count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
  endtask

  task automatic test_lw();
    out_ready = 1'b1;
    issue(MN_LW, 5'd1, 5'd2, 5'd0, 6'd0, 32'h0000_0008, 32'h0);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lw_valid got=%b exp=1", out_valid); end
    total++; if (out_instr !== 32'h8C22_0008) begin bad++; $display("FAIL lw_instr got=%h exp=8c220008", out_instr); end
    total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL lw_addr got=%h exp=0", out_addr); end
    @(negedge clk);
    total++; if (count !== 16'd1) begin bad++; $display("FAIL lw_count got=%0d exp=1", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lw_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_branch();
    issue(MN_BEQ, 5'd1, 5'd2, 5'd0, 6'd0, 32'h0, 32'h0000_0010);
    @(negedge clk);
    total++; if (out_instr !== 32'h1022_0002) begin bad++; $display("FAIL beq_instr got=%h exp=10220002", out_instr); end
    total++; if (out_addr !== 32'h4) begin bad++; $display("FAIL beq_addr got=%h exp=4", out_addr); end
    issue(MN_BLT, 5'd1, 5'd2, 5'd0, 6'd0, 32'h0, 32'h0000_0000);
    @(negedge clk);
    total++; if (out_instr !== 32'h7C22_FFFD) begin bad++; $display("FAIL blt_instr got=%h exp=7c22fffd", out_instr); end
    total++; if (out_addr !== 32'h8) begin bad++; $display("FAIL blt_addr got=%h exp=8", out_addr); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL blt_err got=%b exp=0", err); end
    issue(MN_J, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0, 32'h0000_0100);
    @(negedge clk);
    total++; if (out_instr !== 32'h0800_0040) begin bad++; $display("FAIL j_instr got=%h exp=08000040", out_instr); end
    total++; if (out_addr !== 32'hC) begin bad++; $display("FAIL j_addr got=%h exp=c", out_addr); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL j_err got=%b exp=0", err); end
  endtask

  task automatic test_branch_range();
    do_reset();
    out_ready = 1'b1;
    issue(MN_BEQ, 5'd1, 5'd2, 5'd0, 6'd0, 32'h0, 32'h0004_0000);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL range_valid got=%b exp=1", out_valid); end
    total++; if (out_instr !== 32'h1022_FFFF) begin bad++; $display("FAIL range_instr got=%h exp=1022ffff", out_instr); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL range_err got=%b exp=1", err); end
    issue(MN_LW, 5'd1, 5'd2, 5'd0, 6'd0, 32'h0000_0008, 32'h0);
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    total++; if (out_addr !== 32'h4) begin bad++; $display("FAIL range_next_addr got=%h exp=4", out_addr); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    issue(4'hF, 5'd1, 5'd2, 5'd3, 6'd0, 32'h0, 32'h0);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_valid got=%b exp=0", out_valid); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", err); end
    issue(MN_LW, 5'd1, 5'd2, 5'd0, 6'd0, 32'h0000_0008, 32'h0);
    @(negedge clk);
    total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL illegal_pc got=%h exp=0", out_addr); end
    total++; if (out_instr !== 32'h8C22_0008) begin bad++; $display("FAIL illegal_next got=%h exp=8c220008", out_instr); end
`ifndef ENC_PSEUDO_EN
    do_reset();
    issue(MN_LI32, 5'd0, 5'd5, 5'd0, 6'd0, 32'h1234_5678, 32'h0);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL li32_off_valid got=%b exp=0", out_valid); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL li32_off_err got=%b exp=1", err); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0]  mt [4] = '{4'(MN_SW), 4'(MN_RTYPE), 4'(MN_LUI), 4'(MN_LI)};
    logic [4:0]  rst [4] = '{5'd2, 5'd1, 5'd9, 5'd7};
    logic [4:0]  rtt [4] = '{5'd3, 5'd2, 5'd7, 5'd7};
    logic [4:0]  rdt [4] = '{5'd0, 5'd3, 5'd0, 5'd0};
    logic [5:0]  ft  [4] = '{6'd0, 6'h20, 6'd0, 6'd0};
    logic [31:0] it  [4] = '{32'h0010, 32'h0, 32'hBEEF, 32'h00FF};
    logic [31:0] exp [4] = '{32'hAC43_0010, 32'h0022_1820, 32'h3C07_BEEF, 32'h44E7_00FF};
    do_reset();
    out_ready = 1'b0;
    issue(MN_ADDI, 5'd3, 5'd4, 5'd0, 6'd0, 32'h0000_7FFF, 32'h0);
    set_req(mt[0], rst[0], rtt[0], rdt[0], ft[0], it[0], 32'h0);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=0", k, in_ready); end
      total++; if (out_valid !== 1'b1 || out_instr !== 32'h2064_7FFF)
        begin bad++; $display("FAIL stall_hold[%0d] valid=%b instr=%h exp=1/20647fff", k, out_valid, out_instr); end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) set_req(mt[k+1], rst[k+1], rtt[k+1], rdt[k+1], ft[k+1], it[k+1], 32'h0);
      else in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_instr !== exp[k])
        begin bad++; $display("FAIL b2b_instr[%0d] valid=%b got=%h exp=%h", k, out_valid, out_instr, exp[k]); end
      total++; if (out_addr !== 32'(4 * (k + 1)))
        begin bad++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", k, out_addr, 32'(4 * (k + 1))); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    total++; if (count !== 16'd5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", count); end
  endtask

`ifdef ENC_PSEUDO_EN
  task automatic test_li32();
    do_reset();
    out_ready = 1'b1;
    issue(MN_LI32, 5'd0, 5'd5, 5'd0, 6'd0, 32'h1234_5678, 32'h0);
    @(negedge clk);
    total++; if (out_instr !== 32'h3C05_1234) begin bad++; $display("FAIL li32_w0 got=%h exp=3c051234", out_instr); end
    total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL li32_a0 got=%h exp=0", out_addr); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL li32_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    total++; if (out_instr !== 32'h44A5_5678) begin bad++; $display("FAIL li32_w1 got=%h exp=44a55678", out_instr); end
    total++; if (out_addr !== 32'h4) begin bad++; $display("FAIL li32_a1 got=%h exp=4", out_addr); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || count !== 16'd2)
      begin bad++; $display("FAIL li32_done valid=%b count=%0d exp=0/2", out_valid, count); end
    do_reset();
    out_ready = 1'b0;
    issue(MN_LI32, 5'd0, 5'd5, 5'd0, 6'd0, 32'h1234_5678, 32'h0);
    @(negedge clk);
    total++; if (out_instr !== 32'h3C05_1234) begin bad++; $display("FAIL li32r_w0 got=%h exp=3c051234", out_instr); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL li32r_discard got=%b exp=0", out_valid); end
    end
    issue(MN_LW, 5'd1, 5'd2, 5'd0, 6'd0, 32'h0000_0008, 32'h0);
    @(negedge clk);
    total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL li32r_pc got=%h exp=0", out_addr); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_req(4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0, 32'h0);
    test_reset();
    test_lw();
    test_branch();
    test_branch_range();
    test_illegal();
    test_back_to_back();
`ifdef ENC_PSEUDO_EN
    test_li32();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0000_0000, byte address of the first emitted instruction word.
REQ-002 Ports, one per line:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  encoder accepts a request this cycle.
- in_mnem  input  4  mnemonic code (enc_mnem_t).
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_funct  input  6  R-type funct field.
- in_imm  input  32  immediate; only [15:0] is used except by LI32.
- in_target  input  32  absolute byte target for BEQ/BLT/J.
- out_valid  output  1  encoded word present.
- out_ready  input  1  downstream (instruction-memory writer) accepts the word.
- out_instr  output  32  encoded instruction word.
- out_addr  output  32  byte address of out_instr.
- err  output  1  sticky error flag.
- count  output  16  number of words emitted (saturating).

Function
REQ-003 Handshake: transfer on a rising edge where valid and ready are both high; in_ready = !out_valid || out_ready, forced low during EXPAND.
REQ-004 Latency: one cycle from input acceptance to out_valid; a single output register supports full throughput, one word per cycle.
REQ-005 Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, LUI 001111, LI 010001, BLT 011111.
REQ-006 RTYPE word = {000000, rs, rt, rd, 00000, funct}.
REQ-007 LW, SW, ADDI, LI words = {op, rs, rt, imm[15:0]}.
REQ-008 LUI word = {op, 00000, rt, imm[15:0]}.
REQ-009 BEQ/BLT offset = (in_target - (pc + 4)) >>> 2, computed in 32-bit signed arithmetic; word = {op, rs, rt, offset[15:0]}.
REQ-010 BEQ/BLT range error: when the offset does not fit in signed 16 bits, or in_target[1:0] != 0, set err and emit the word with offset[15:0] (truncated).
REQ-011 J word = {000010, in_target[27:2]}; set err when in_target[31:28] != (pc+4)[31:28] or in_target[1:0] != 0.
REQ-012 Illegal mnemonic: set err, emit no word, do not advance pc; in_ready behaves normally.
REQ-013 pc register: out_addr = pc of the current word; pc += 4 on each output transfer, wrapping modulo 2^32.
REQ-014 count increments on each output transfer and saturates at 16'hFFFF.
REQ-015 err is sticky until reset.
REQ-016 States:
- IDLE: no word held.
- HOLD: out_valid high.
- EXPAND: LI32 second word pending (config only).
REQ-017 IDLE -> HOLD on acceptance. HOLD -> HOLD on a simultaneous out transfer plus new acceptance. HOLD -> IDLE on an out transfer with no acceptance.
REQ-018 out_valid and out_instr hold stable while out_valid && !out_ready.

Reset
REQ-019 reset, sampled high at a clock edge, sets:
- state = IDLE, out_valid = 0, out_instr = 0, out_addr = BASE_ADDR.
- pc = BASE_ADDR, err = 0, count = 0.
- any pending EXPAND word is discarded.
REQ-020 in_ready is high in the first cycle after reset is released.

Configuration
REQ-021 Macro ENC_PSEUDO_EN.
- When defined: mnemonic LI32 is legal and expands to two consecutive words, LUI rt, imm[31:16] then LI rt, rt, imm[15:0] (LI ORs the zero-extended immediate). Each word occupies its own address. The state is EXPAND between the two words, and in_ready stays low until the second word transfers.
- When undefined: LI32 is illegal (REQ-012) and the EXPAND state does not exist.

Structure
REQ-022 Package enc_pkg holds the enc_mnem_t enum, the opcode localparams (shared with maindec), and the state enum.
REQ-023 One sub-module, enc_field, computes the branch offset and jump field together with their range-error flags.

Verification
REQ-024 After reset with BASE_ADDR=0: LW rs=1 rt=2 imm=0x0008 -> out_instr 8C220008, out_addr 0, count 1.
REQ-025 BEQ rs=1 rt=2 target=0x10 at pc=0x4 -> 10220002. BLT target=0x0 at pc=0x8 -> offset FFFD, err stays 0.
REQ-026 BEQ target=0x40000 at pc=0 -> err=1 and the word is still emitted.
REQ-027 Hold out_ready low for 3 cycles with in_valid high -> in_ready low and out_instr stable; then 4 back-to-back requests with out_ready high -> 4 words on consecutive cycles with addresses +4 each.
REQ-028 ENC_PSEUDO_EN defined: LI32 rt=5 imm=0x12345678 -> 3C051234 then 44A55678 at consecutive addresses. Assert reset between the two words -> no second word, pc=BASE_ADDR.
REQ-029 Illegal mnemonic 4'hF -> err=1, no out_valid, pc unchanged.
